// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and decimal entry accumulator.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } state_t;

   localparam logic [3:0]  KEY_BKSP  = 4'hA;
   localparam logic [3:0]  KEY_CLR   = 4'hB;
   localparam logic [3:0]  KEY_ENTER = 4'hC;
   localparam logic [13:0] MAX_ENTRY = 14'd9999;

   // Lowest-index active-low row; only meaningful when at least one row is low.
   function automatic logic [1:0] low_row(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// One-clock scan_tick every CLK_DIV clocks, from a down-counter with terminal-count reload.
module scan_tick_gen #(
   parameter int CLK_DIV = 100_000
) (
   input  logic clk,
   input  logic reset,
   output logic scan_tick
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div;

   always_ff @(posedge clk) begin
      if (!reset) begin
         div       <= '0;
         scan_tick <= 1'b0;
      end else if (div == '0) begin
         div       <= DW'(CLK_DIV - 1);
         scan_tick <= 1'b1;
      end else begin
         div       <= div - 1'b1;
         scan_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with press/release debounce and a 0..9999 decimal entry accumulator.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// SCAN       | rotate active column each tick until a row reads low
// DEBOUNCE   | count consecutive low samples of the captured row
// HELD       | key accepted, column frozen, other keys ignored
// RELEASE    | count consecutive all-high samples before resuming scan
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int CLK_DIV        = 100_000,
   parameter int DEBOUNCE_TICKS = 4        // must be >= 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [3:0]  colDrive,
   input  logic [3:0]  rowSense,
   output logic [3:0]  keyCode,
   output logic        keyValid,
   output logic [13:0] entry,
   output logic [13:0] number,
   output logic        numberValid
);

   localparam int            CW       = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);

   state_t        state;
   logic [1:0]    col;
   logic [1:0]    row_cap;
   logic [CW-1:0] cnt;
   logic          scan_tick;
   logic          row_any_low;
   logic          cap_low;
   logic [16:0]   digit_ext;

   scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk       (clk),
      .reset     (reset),
      .scan_tick (scan_tick)
   );

   assign colDrive    = ~(4'b0001 << col);
   assign row_any_low = ~&rowSense;
   assign cap_low     = ~rowSense[row_cap];
   // 17 bits so 9999*10+9 cannot wrap before the range check
   assign digit_ext   = ({3'b000, entry} * 17'd10) + {13'd0, keyCode};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_SCAN;
         col      <= 2'd0;
         row_cap  <= 2'd0;
         cnt      <= '0;
         keyCode  <= 4'd0;
         keyValid <= 1'b0;
      end else begin
         keyValid <= 1'b0;
         if (scan_tick) begin
            case (state)
               ST_SCAN: begin
                  if (row_any_low) begin
                     row_cap <= low_row(rowSense);
                     cnt     <= CW'(1);
                     state   <= ST_DEBOUNCE;
                  end else begin
                     col <= col + 2'd1;
                  end
               end
               ST_DEBOUNCE: begin
                  if (!cap_low) begin
                     state <= ST_SCAN;
                  end else if (cnt + 1'b1 == CNT_DONE) begin
                     keyCode  <= {row_cap, col};
                     keyValid <= 1'b1;
                     state    <= ST_HELD;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_HELD: begin
                  if (!row_any_low) begin
                     cnt   <= CW'(1);
                     state <= ST_RELEASE;
                  end
               end
               ST_RELEASE: begin
                  if (row_any_low) begin
                     state <= ST_HELD;
                  end else if (cnt + 1'b1 == CNT_DONE) begin
                     col   <= col + 2'd1;
                     state <= ST_SCAN;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= ST_SCAN;
            endcase
         end
      end
   end

   // Acts on the registered keyCode one clock after the keyValid pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         entry       <= 14'd0;
         number      <= 14'd0;
         numberValid <= 1'b0;
      end else begin
         numberValid <= 1'b0;
         if (keyValid) begin
            if (keyCode <= 4'd9) begin
               if (digit_ext <= {3'b000, MAX_ENTRY}) entry <= digit_ext[13:0];
            end else if (keyCode == KEY_BKSP) begin
               entry <= entry / 14'd10;
            end else if (keyCode == KEY_CLR) begin
               entry <= 14'd0;
            end else if (keyCode == KEY_ENTER) begin
               number      <= entry;
               entry       <= 14'd0;
               numberValid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a 4x4 switch-matrix model driving rowSense.
module tb_keypad_entry;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  colDrive;
   logic [3:0]  rowSense;
   logic [3:0]  keyCode;
   logic        keyValid;
   logic [13:0] entry;
   logic [13:0] number;
   logic        numberValid;

   logic [15:0] pressed = 16'd0;   // bit index = {row, col}
   logic [3:0]  raw_low = 4'd0;    // rows forced low regardless of column

   int n_cmp = 0;
   int n_err = 0;
   int kv_cnt = 0, nv_cnt = 0, kv_dbl = 0, nv_dbl = 0, chg_cnt = 0;
   logic kv_prev = 1'b0, nv_prev = 1'b0;
   logic [3:0] col_prev = 4'hE;
   logic [3:0] col_q[$];

   keypad_entry #(.CLK_DIV(10), .DEBOUNCE_TICKS(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .colDrive    (colDrive),
      .rowSense    (rowSense),
      .keyCode     (keyCode),
      .keyValid    (keyValid),
      .entry       (entry),
      .number      (number),
      .numberValid (numberValid)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int r = 0; r < 4; r++)
         rowSense[r] = !(raw_low[r] || |(pressed[r*4 +: 4] & ~colDrive));
   end

   always @(negedge clk) begin
      if (keyValid) kv_cnt++;
      if (keyValid && kv_prev) kv_dbl++;
      if (numberValid) nv_cnt++;
      if (numberValid && nv_prev) nv_dbl++;
      kv_prev = keyValid;
      nv_prev = numberValid;
      if (colDrive !== col_prev) begin
         chg_cnt++;
         col_q.push_back(colDrive);
      end
      col_prev = colDrive;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_kv(input int budget, output bit seen, output int cycles);
      seen = 1'b0;
      cycles = 0;
      while (cycles < budget && !seen) begin
         @(negedge clk);
         cycles++;
         if (keyValid) seen = 1'b1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_col"},   colDrive,    4'hE);
      check_val({tag, "_code"},  keyCode,     4'h0);
      check_val({tag, "_kv"},    keyValid,    1'b0);
      check_val({tag, "_entry"}, entry,       14'd0);
      check_val({tag, "_num"},   number,      14'd0);
      check_val({tag, "_nv"},    numberValid, 1'b0);
   endtask

   task automatic press_key(input logic [3:0] k, input logic [13:0] exp_entry);
      bit seen;
      int cyc;
      pressed[k] = 1'b1;
      wait_kv(400, seen, cyc);
      check_val($sformatf("kv_seen_%h", k), seen, 1'b1);
      check_val($sformatf("key_code_%h", k), keyCode, k);
      @(negedge clk);
      check_val($sformatf("entry_after_%h", k), entry, exp_entry);
      repeat (30) @(negedge clk);
      pressed[k] = 1'b0;
      repeat (80) @(negedge clk);
   endtask

   initial begin
      logic [3:0] exp_seq [5];
      int kv0, nv0, c0, cyc;
      bit seen;
      logic [3:0] cd;

      exp_seq = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD};

      // reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      col_q.delete();

      // idle scanning
      reset = 1'b1;
      repeat (85) @(negedge clk);
      check_val("idle_steps", col_q.size() >= 8, 1'b1);
      for (int i = 0; i < 5; i++)
         if (i < col_q.size()) check_val($sformatf("idle_col_%0d", i), col_q[i], exp_seq[i]);
      check_val("idle_no_kv", kv_cnt, 0);

      // single key row1/col2
      kv0 = kv_cnt;
      press_key(4'h6, 14'd6);
      check_val("key6_one_kv", kv_cnt - kv0, 1);
      c0 = chg_cnt;
      repeat (50) @(negedge clk);
      check_val("scan_resume", (chg_cnt - c0) >= 4, 1'b1);

      // two-tick bounce on row 1
      kv0 = kv_cnt;
      raw_low = 4'b0010;
      repeat (20) @(negedge clk);
      raw_low = 4'b0000;
      repeat (60) @(negedge clk);
      check_val("bounce_no_kv", kv_cnt - kv0, 0);
      c0 = chg_cnt;
      repeat (50) @(negedge clk);
      check_val("bounce_scan", (chg_cnt - c0) >= 4, 1'b1);

      // clear, digits with overflow, backspace
      press_key(4'hB, 14'd0);
      press_key(4'h1, 14'd1);
      press_key(4'h2, 14'd12);
      press_key(4'h3, 14'd123);
      press_key(4'h4, 14'd1234);
      press_key(4'h5, 14'd1234);
      press_key(4'hA, 14'd123);

      // enter
      nv0 = nv_cnt;
      pressed[4'hC] = 1'b1;
      wait_kv(400, seen, cyc);
      check_val("enter_seen", seen, 1'b1);
      check_val("enter_code", keyCode, 4'hC);
      check_val("enter_nv_early", numberValid, 1'b0);
      @(negedge clk);
      check_val("enter_nv", numberValid, 1'b1);
      check_val("enter_number", number, 14'd123);
      check_val("enter_entry", entry, 14'd0);
      @(negedge clk);
      check_val("enter_nv_drop", numberValid, 1'b0);
      repeat (30) @(negedge clk);
      pressed[4'hC] = 1'b0;
      repeat (80) @(negedge clk);
      check_val("enter_nv_count", nv_cnt - nv0, 1);

      // rows 0 and 2 together on col 0, then a second key while held
      pressed[4'h0] = 1'b1;
      pressed[4'h8] = 1'b1;
      wait_kv(400, seen, cyc);
      check_val("multi_seen", seen, 1'b1);
      check_val("multi_code", keyCode, 4'h0);
      @(negedge clk);
      kv0 = kv_cnt;
      pressed[4'h4] = 1'b1;
      repeat (60) @(negedge clk);
      check_val("held_ignore", kv_cnt - kv0, 0);
      pressed = 16'd0;
      repeat (80) @(negedge clk);

      // reset at debounce count 3: align to a scan step first
      cd = colDrive;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (colDrive !== cd) break;
      end
      raw_low = 4'b1000;
      repeat (35) @(negedge clk);
      kv0 = kv_cnt;
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      repeat (3) @(negedge clk);
      check_val("mid_rst_no_kv", kv_cnt - kv0, 0);
      reset = 1'b1;
      wait_kv(400, seen, cyc);
      check_val("fresh_seen", seen, 1'b1);
      check_val("fresh_code", keyCode, 4'hC);
      check_val("fresh_debounced", cyc >= 30, 1'b1);
      @(negedge clk);
      check_val("fresh_nv", numberValid, 1'b1);
      check_val("fresh_number", number, 14'd0);
      raw_low = 4'b0000;
      repeat (80) @(negedge clk);

      check_val("kv_single_cycle", kv_dbl, 0);
      check_val("nv_single_cycle", nv_dbl, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
